alu_issue_stage: RTL and testbench

Register-file-and-sequencing stage wrapped around the combinational ALU. Accepts one register/immediate instruction at a time over a valid/ready handshake, reads operands from a 16×16 register file, drives the ALU, captures its result and flags, then writes the result back and updates the processor status register (PSR). It is both the ALU's upstream operand source and its downstream result consumer.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_issue_stage_regfile.sv | 34 +++
 rtl/alu_issue_stage.sv | 132 +++++++++++++
 tb/tb_alu_issue_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: opcodes, widths, sequencing states.
// Imported by the issue stage, its register file and benches.
package alu_pkg;

  localparam int DW    = 16;
  localparam int FW    = 5;
  localparam int NREGS = 16;
  localparam int AW    = 4;
  localparam int OPW   = 5;

  localparam logic [OPW-1:0] OP_ADD  = 5'd0;
  localparam logic [OPW-1:0] OP_SUB  = 5'd1;
  localparam logic [OPW-1:0] OP_CMP  = 5'd2;
  localparam logic [OPW-1:0] OP_AND  = 5'd3;
  localparam logic [OPW-1:0] OP_OR   = 5'd4;
  localparam logic [OPW-1:0] OP_XOR  = 5'd5;
  localparam logic [OPW-1:0] OP_NOT  = 5'd6;
  localparam logic [OPW-1:0] OP_LSH  = 5'd7;
  localparam logic [OPW-1:0] OP_RSH  = 5'd8;
  localparam logic [OPW-1:0] OP_ARSH = 5'd9;
  localparam logic [OPW-1:0] OP_NOP  = 5'b01111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  // Logical ops take the immediate as an unsigned mask.
  function automatic logic [DW-1:0] ext_imm(
    input logic [OPW-1:0] op,
    input logic [7:0]     imm
  );
    logic [DW-1:0] v;
    unique case (1'b1)
      (op == OP_AND),
      (op == OP_OR),
      (op == OP_XOR): v = {8'h00, imm};
      default:        v = {{8{imm[7]}}, imm};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// 16x16 register file: two operand reads, one debug read,
// one synchronous write, asynchronous clear.
module regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a   = mem[raddr_a];
  assign rdata_b   = mem[raddr_b];
  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch, ALU sequencing and writeback around the
// combinational ALU; one instruction every four cycles.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] op,
  input  logic [AW-1:0]  src_idx,
  input  logic [AW-1:0]  dest_idx,
  input  logic           imm_en,
  input  logic [7:0]     imm,
  output logic [DW-1:0]  alu_rsrc,
  output logic [DW-1:0]  alu_rdest,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_out,
  input  logic [FW-1:0]  alu_flags,
  output logic [FW-1:0]  psr,
  output logic           done,
  input  logic [AW-1:0]  dbg_idx,
  output logic [DW-1:0]  dbg_data
);

  state_t state, state_nx;

  logic [OPW-1:0] op_q;
  logic [AW-1:0]  src_q;
  logic [AW-1:0]  dest_q;
  logic           imm_en_q;
  logic [7:0]     imm_q;

  logic [DW-1:0]  a_q;
  logic [DW-1:0]  b_q;
  logic [DW-1:0]  res_q;
  logic [FW-1:0]  flg_q;
  logic [FW-1:0]  psr_q;

  logic [DW-1:0]  rd_a;
  logic [DW-1:0]  rd_b;
  logic           accept;
  logic           we;

  regfile u_rf (
    .clk       (clk),
    .reset     (reset),
    .raddr_a   (src_q),
    .raddr_b   (dest_q),
    .rdata_a   (rd_a),
    .rdata_b   (rd_b),
    .dbg_addr  (dbg_idx),
    .dbg_rdata (dbg_data),
    .we        (we),
    .waddr     (dest_q),
    .wdata     (res_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    alu_op      = OP_NOP;
    unique case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = S_READ;
      end
      S_READ: state_nx = S_EXEC;
      S_EXEC: begin
        alu_op   = op_q;
        state_nx = S_WB;
      end
      S_WB: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
    endcase
  end

  assign accept = instr_ready & instr_valid;
  // CMP only updates flags, never the destination.
  assign we     = done & (op_q != OP_CMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_NOP;
      src_q    <= '0;
      dest_q   <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
    end else if (accept) begin
      op_q     <= op;
      src_q    <= src_idx;
      dest_q   <= dest_idx;
      imm_en_q <= imm_en;
      imm_q    <= imm;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      flg_q <= '0;
      psr_q <= '0;
    end else begin
      if (state == S_READ) begin
        a_q <= imm_en_q ? ext_imm(op_q, imm_q)
                        : rd_a;
        b_q <= rd_b;
      end
      if (state == S_EXEC) begin
        res_q <= alu_out;
        flg_q <= alu_flags;
      end
      if (state == S_WB)
        psr_q <= flg_q;
    end
  end

  assign alu_rsrc  = a_q;
  assign alu_rdest = b_q;
  assign psr       = psr_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural ALU and an
// instruction-level register/PSR model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  op;
  logic [3:0]  src_idx;
  logic [3:0]  dest_idx;
  logic        imm_en;
  logic [7:0]  imm;
  logic [15:0] alu_rsrc;
  logic [15:0] alu_rdest;
  logic [4:0]  alu_op;
  logic [15:0] alu_out;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        done;
  logic [3:0]  dbg_idx;
  logic [15:0] dbg_data;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_rf [16];
  logic [4:0]  m_psr;

  alu_issue_stage dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op          (op),
    .src_idx     (src_idx),
    .dest_idx    (dest_idx),
    .imm_en      (imm_en),
    .imm         (imm),
    .alu_rsrc    (alu_rsrc),
    .alu_rdest   (alu_rdest),
    .alu_op      (alu_op),
    .alu_out     (alu_out),
    .alu_flags   (alu_flags),
    .psr         (psr),
    .done        (done),
    .dbg_idx     (dbg_idx),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Flags: {carry, lower, overflow, zero, negative}
  function automatic logic [20:0] alu_ref(
    input logic [4:0]  o,
    input logic [15:0] rs,
    input logic [15:0] rd
  );
    logic [16:0] w;
    logic [15:0] r;
    logic        c;
    logic        f;
    c = 1'b0;
    f = 1'b0;
    w = '0;
    if (o == 5'd15) return 21'd0;
    case (o)
      5'd0: begin
        w = {1'b0, rd} + {1'b0, rs};
        r = w[15:0];
        c = w[16];
        f = (rd[15] == rs[15]) && (r[15] != rd[15]);
      end
      5'd1, 5'd2: begin
        w = {1'b0, rd} - {1'b0, rs};
        r = w[15:0];
        c = w[16];
        f = (rd[15] != rs[15]) && (r[15] != rd[15]);
      end
      5'd3: r = rd & rs;
      5'd4: r = rd | rs;
      5'd5: r = rd ^ rs;
      5'd6: r = ~rs;
      5'd7: r = rd << rs[3:0];
      5'd8: r = rd >> rs[3:0];
      5'd9: r = 16'($signed(rd) >>> rs[3:0]);
      default: r = rd ^ {rs[7:0], rs[15:8]};
    endcase
    return {c, rd < rs, f, r == 16'd0, r[15], r};
  endfunction

  always_comb
    {alu_flags, alu_out} = alu_ref(alu_op, alu_rsrc, alu_rdest);

  function automatic logic [15:0] ext(
    input logic [4:0] o,
    input logic [7:0] im
  );
    if (o == 5'd3 || o == 5'd4 || o == 5'd5)
      return {8'h00, im};
    return {{8{im[7]}}, im};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic garble(input logic v);
    op          = 5'($urandom);
    src_idx     = 4'($urandom);
    dest_idx    = 4'($urandom);
    imm_en      = 1'($urandom);
    imm         = 8'($urandom);
    instr_valid = v ? 1'($urandom) : 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_psr = '0;
  endtask

  task automatic issue(
    input  logic [4:0]  o,
    input  logic [3:0]  s,
    input  logic [3:0]  d,
    input  logic        ie,
    input  logic [7:0]  im,
    output logic [15:0] xr
  );
    logic [15:0] a;
    logic [15:0] b;
    logic [20:0] y;
    int n;
    n = 0;
    while (!instr_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("ready_idle", 32'(instr_ready), 1);
    a = ie ? ext(o, im) : m_rf[s];
    b = m_rf[d];
    y = alu_ref(o, a, b);
    op = o; src_idx = s; dest_idx = d;
    imm_en = ie; imm = im; instr_valid = 1'b1;
    @(negedge clk);
    chk("read_ready", 32'(instr_ready), 0);
    chk("read_done", 32'(done), 0);
    chk("read_op", 32'(alu_op), 32'h0f);
    garble(1'b1);
    @(negedge clk);
    chk("exec_op", 32'(alu_op), 32'(o));
    chk("exec_rsrc", 32'(alu_rsrc), 32'(a));
    chk("exec_rdest", 32'(alu_rdest), 32'(b));
    chk("exec_done", 32'(done), 0);
    xr = alu_rsrc;
    garble(1'b1);
    @(negedge clk);
    chk("wb_done", 32'(done), 1);
    chk("wb_ready", 32'(instr_ready), 0);
    chk("wb_psr_old", 32'(psr), 32'(m_psr));
    garble(1'b0);
    @(negedge clk);
    if (o != 5'd2) m_rf[d] = y[15:0];
    m_psr = y[20:16];
    dbg_idx = d;
    #1;
    chk("wb_rf", 32'(dbg_data), 32'(m_rf[d]));
    chk("wb_psr", 32'(psr), 32'(m_psr));
    chk("idle_done", 32'(done), 0);
  endtask

  task automatic load(input logic [3:0] r, input logic [15:0] v);
    logic [15:0] x;
    issue(5'd5, r, r, 1'b0, 8'h00, x);
    issue(5'd4, r, r, 1'b1, v[15:8], x);
    issue(5'd7, r, r, 1'b1, 8'd8, x);
    issue(5'd4, r, r, 1'b1, v[7:0], x);
  endtask

  logic [15:0] xr;
  logic [20:0] yv;
  logic [3:0]  ra, rb;
  logic [15:0] va, vb;
  logic [4:0]  hold_psr;
  int k, prev;

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    op = '0; src_idx = '0; dest_idx = '0;
    imm_en = 1'b0; imm = '0; dbg_idx = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_psr", 32'(psr), 0);
    chk("rst_aluop", 32'(alu_op), 32'h0f);
    chk("rst_rsrc", 32'(alu_rsrc), 0);
    chk("rst_rdest", 32'(alu_rdest), 0);
    for (int i = 0; i < 16; i++) begin
      dbg_idx = 4'(i);
      #1;
      chk("rst_rf", 32'(dbg_data), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(5'd0, 4'd0, 4'd1, 1'b1, 8'h05, xr);
    dbg_idx = 4'd1; #1;
    chk("add_imm_r1", 32'(dbg_data), 5);
    issue(5'd0, 4'd1, 4'd1, 1'b0, 8'h00, xr);
    dbg_idx = 4'd1; #1;
    chk("add_r1_r1", 32'(dbg_data), 10);

    issue(5'd1, 4'd0, 4'd2, 1'b1, 8'hff, xr);
    chk("sub_sext", 32'(xr), 32'hffff);
    issue(5'd3, 4'd0, 4'd2, 1'b1, 8'hff, xr);
    chk("and_zext", 32'(xr), 32'h00ff);

    load(4'd3, 16'd7);
    load(4'd4, 16'd7);
    issue(5'd2, 4'd3, 4'd4, 1'b0, 8'h00, xr);
    yv = alu_ref(5'd2, 16'd7, 16'd7);
    dbg_idx = 4'd4; #1;
    chk("cmp_r4", 32'(dbg_data), 7);
    chk("cmp_psr", 32'(psr), 32'(yv[20:16]));

    issue(5'd20, 4'd3, 4'd2, 1'b0, 8'h00, xr);
    issue(5'd31, 4'd1, 4'd1, 1'b1, 8'h81, xr);

    k = 0; prev = 0; hold_psr = m_psr;
    for (int c = 0; c < 12; c++) begin
      if (instr_ready) begin
        if (k > 0) chk("hold_gap", 32'(c - prev), 4);
        chk("hold_count_lim", 32'(k < 3), 1);
        prev = c;
        op = 5'd0; src_idx = 4'd0;
        dest_idx = 4'(6 + k); imm_en = 1'b1;
        imm = 8'(10 + k); instr_valid = 1'b1;
        yv = alu_ref(5'd0, 16'(10 + k), m_rf[6 + k]);
        m_rf[6 + k] = yv[15:0];
        hold_psr = yv[20:16];
        k++;
      end else begin
        garble(1'b0);
        instr_valid = 1'b1;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    m_psr = hold_psr;
    chk("hold_accepts", 32'(k), 3);
    chk("hold_ready", 32'(instr_ready), 1);
    for (int i = 6; i < 9; i++) begin
      dbg_idx = 4'(i); #1;
      chk("hold_rf", 32'(dbg_data), 32'(m_rf[i]));
    end
    chk("hold_psr", 32'(psr), 32'(m_psr));

    load(4'd5, 16'd9);
    dbg_idx = 4'd5; #1;
    chk("r5_loaded", 32'(dbg_data), 9);
    op = 5'd0; src_idx = 4'd0; dest_idx = 4'd5;
    imm_en = 1'b1; imm = 8'd3; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_exec", 32'(alu_op), 0);
    reset = 1'b1;
    #1;
    model_reset();
    dbg_idx = 4'd5; #1;
    chk("abort_r5", 32'(dbg_data), 0);
    chk("abort_psr", 32'(psr), 0);
    chk("abort_ready", 32'(instr_ready), 1);
    chk("abort_aluop", 32'(alu_op), 32'h0f);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(instr_ready), 1);
    chk("post_rst_done", 32'(done), 0);
    issue(5'd0, 4'd0, 4'd5, 1'b1, 8'd4, xr);
    dbg_idx = 4'd5; #1;
    chk("post_rst_r5", 32'(dbg_data), 4);

    for (int o = 0; o < 10; o++) begin
      for (int i = 0; i < 64; i++) begin
        ra = 4'($urandom);
        rb = 4'($urandom);
        va = 16'($urandom);
        vb = 16'($urandom);
        load(ra, va);
        load(rb, vb);
        issue(5'(o), ra, rb,
              ($urandom_range(3) == 0),
              8'($urandom), xr);
      end
    end
    for (int i = 0; i < 16; i++) begin
      dbg_idx = 4'(i); #1;
      chk("final_rf", 32'(dbg_data), 32'(m_rf[i]));
    end
    chk("final_psr", 32'(psr), 32'(m_psr));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
